cash_display_ctrl: RTL
======================

# cash_display_ctrl

Controller for the on-screen cash amount field that sits beside the "CASH" label in the VGA overlay. It accepts a binary amount over a valid/ready handshake and converts it to BCD over multiple cycles with a sequential double-dabble. The new digits are committed to the displayed register only at a frame boundary, so a frame never tears. A 2-stage pixel pipeline then renders the digits from an internal 8x8 digit font, producing a `visible` bit for the pixel mux.

## Interface
Parameters:
- `SCALE`, 1, integer font magnification (glyph cell is 8·SCALE × 8·SCALE pixels)
- `DIGITS`, 5, number of decimal digits shown
- `VAL_W`, 17, width of the binary amount input

Ports:
- `clk` input 1: single clock; the pixel coordinates are sampled on it
- `rst` input 1: synchronous, active-high reset
- `Q_X`, `Q_Y` input 10 each: current pixel coordinate from VGA timing
- `pos_x`, `pos_y` input 10 each: top-left corner of the digit field; quasi-static
- `frame_start` input 1: one-cycle pulse at the start of vertical blanking
- `amt` input VAL_W: binary cash amount
- `amt_valid` input 1: `amt` is valid
- `amt_ready` output 1: block can accept an amount
- `busy` output 1: a conversion or commit is pending
- `overflow` output 1: the displayed value was saturated
- `visible` output 1: the current pixel belongs to a lit digit pixel

## Operation
- FSM states: IDLE → CONVERT → PENDING → IDLE.
- IDLE
  - `amt_ready`=1 and `busy`=0.
  - When `amt_valid`&&`amt_ready`, the block latches `amt`, clears the BCD scratch register, loads the iteration counter with VAL_W, and goes to CONVERT.
- CONVERT
  - One double-dabble iteration per cycle: add 3 to every BCD nibble ≥5, then shift left one bit, pulling in the binary MSB.
  - Exactly VAL_W cycles, then go to PENDING.
  - Saturation: if the latched `amt` > 10^DIGITS−1, the scratch register is forced to all 9s and `sat`=1. The compare is done at acceptance.
- PENDING
  - Waits for `frame_start`; `frame_start` is sampled only in this state.
  - On `frame_start`, the scratch register is copied to the display digit register, `overflow` is set to `sat`, and the FSM returns to IDLE in the same edge.
- Amounts offered outside IDLE are not accepted. `amt_valid` must stay asserted until the handshake completes.
- Pixel pipeline
  - Runs every cycle, independent of the FSM. It always reads the display register, never the scratch register.
  - Zone: `Q_X` ∈ [pos_x, pos_x + DIGITS·8·SCALE) and `Q_Y` ∈ [pos_y, pos_y + 8·SCALE).
  - dx = Q_X−pos_x, dy = Q_Y−pos_y.
  - Digit index = dx/(8·SCALE); index 0 is the leftmost digit and the most significant one.
  - Column = (dx/SCALE)%8; row = dy/SCALE.
  - Stage 1 registers zone, digit value, row and column. Stage 2 registers the font row and outputs `visible` = zone && row_bits[7−col].
  - Font: glyphs 0–9, 8 rows × 8 bits, MSB = leftmost pixel.
- Arithmetic
  - dx and dy are computed in 11 bits, so no wrap occurs when Q < pos.
  - The zone compare is done first; dx and dy are don't-care outside the zone.

## Timing
- `visible` for coordinate (Q_X, Q_Y) appears 2 cycles after that coordinate is presented.
- Handshake to commit: acceptance edge, then VAL_W CONVERT cycles, then wait for the first `frame_start` seen in PENDING.
  - A `frame_start` that coincides with the last CONVERT cycle is missed; the commit waits for the next frame.
- `amt_ready` rises on the cycle after the commit edge.
- Reset values:
  - FSM in IDLE, `amt_ready`=1, `busy`=0, `overflow`=0, `visible`=0.
  - Display register = all zeros, scratch register = 0, pipeline registers = 0.
- Reset mid-CONVERT or mid-PENDING discards the conversion. The display returns to zero and the amount is not committed.

## Configuration
- `CASH_LZB_EN` defined: leading-zero blanking.
  - A digit is blank (`visible`=0) if it is 0 and all more significant digits are 0.
  - The least significant digit is never blanked, so 0 renders as a single "0".
- `CASH_LZB_EN` undefined: all DIGITS digits always render, with zeros shown as "0" glyphs.

## Test plan
- After reset, no amount sent: the field shows "00000" without the macro, or a single "0" at digit 4 with it. `overflow`=0.
- Offer `amt`=1234 in IDLE:
  - `amt_ready` drops on the next cycle and `busy` stays high for 17 cycles plus the wait for `frame_start`.
  - After `frame_start` the field reads 01234, or 1234 with leading-zero blanking.
- Offer `amt`=120000, which is >99999: after the commit the field reads 99999 and `overflow`=1. A following `amt`=5 clears `overflow` on its commit.
- Pulse `frame_start` on the last CONVERT cycle: the display is unchanged. The commit happens on the next `frame_start`, and `busy` stays 1 until then.
- Hold `amt_valid` with a new value during CONVERT: it is not accepted; it is accepted only on the first IDLE cycle. Assert `rst` in PENDING: the display reads 0 and no commit occurs.
- Sweep Q_X across the field with SCALE=2 and pos_x=100:
  - `visible` follows the glyph bit pattern with 2-cycle latency.
  - `visible`=0 at Q_X=99 and at Q_X=100+80=180.

Source files
------------

// File: rtl/cash_display_ctrl_if.sv
// Amount handshake between the game logic and the cash display controller.
interface cash_display_ctrl_if #(
  parameter int unsigned VAL_W = 17
);
  logic [VAL_W-1:0] amt;
  logic             amt_valid;
  logic             amt_ready;

  modport master (output amt, output amt_valid, input amt_ready);
  modport slave  (input amt, input amt_valid, output amt_ready);
endinterface

// File: rtl/cash_display_ctrl.sv
// Cash amount overlay: sequential double-dabble, frame-synchronous commit, 2-stage glyph renderer.
// Optional leading-zero blanking is enabled by defining CASH_LZB_EN.
module cash_display_ctrl #(
  parameter int unsigned SCALE  = 1,
  parameter int unsigned DIGITS = 5,
  parameter int unsigned VAL_W  = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          Q_X,
  input  logic [9:0]          Q_Y,
  input  logic [9:0]          pos_x,
  input  logic [9:0]          pos_y,
  input  logic                frame_start,
  cash_display_ctrl_if.slave  bus,
  output logic                busy,
  output logic                overflow,
  output logic                visible
);

  localparam int unsigned BcdW   = 4 * DIGITS;
  localparam int unsigned CntW   = $clog2(VAL_W + 1);
  localparam int unsigned FieldW = DIGITS * 8 * SCALE;
  localparam int unsigned CellH  = 8 * SCALE;

  function automatic logic [63:0] max_val(int unsigned n);
    logic [63:0] v;
    v = 64'd1;
    for (int unsigned i = 0; i < n; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MaxVal = max_val(DIGITS);

  // Rows top to bottom, MSB of each byte is the leftmost pixel.
  function automatic logic [63:0] glyph(logic [3:0] d);
    case (d)
      4'd0:    return 64'h3C666E7666663C00;
      4'd1:    return 64'h183818181818_7E00;
      4'd2:    return 64'h3C66060C30607E00;
      4'd3:    return 64'h3C66061C06663C00;
      4'd4:    return 64'h0C1C3C6C7E0C0C00;
      4'd5:    return 64'h7E607C0606663C00;
      4'd6:    return 64'h3C607C6666663C00;
      4'd7:    return 64'h7E060C1830303000;
      4'd8:    return 64'h3C66663C66663C00;
      4'd9:    return 64'h3C66663E060C3800;
      default: return 64'h0;
    endcase
  endfunction

  typedef enum logic [1:0] {StIdle, StConvert, StPending} state_e;

  state_e            state_q, state_d;
  logic [VAL_W-1:0]  shreg_q;
  logic [BcdW-1:0]   scratch_q, adj;
  logic [BcdW-1:0]   disp_q;
  logic [CntW-1:0]   cnt_q;
  logic              sat_q, sat_in;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (bus.amt_valid) state_d = StConvert;
      StConvert: if (cnt_q == CntW'(1)) state_d = StPending;
      StPending: if (frame_start) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.amt_ready = (state_q == StIdle);
    busy          = (state_q != StIdle);
  end

  assign sat_in = 64'(bus.amt) > MaxVal;

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      disp_q    <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.amt_valid) begin
            shreg_q   <= bus.amt;
            scratch_q <= sat_in ? {DIGITS{4'h9}} : '0;
            sat_q     <= sat_in;
            cnt_q     <= CntW'(VAL_W);
          end
        end
        StConvert: begin
          cnt_q   <= cnt_q - CntW'(1);
          shreg_q <= shreg_q << 1;
          // A saturated amount keeps its preset nines.
          if (!sat_q) scratch_q <= {adj[BcdW-2:0], shreg_q[VAL_W-1]};
        end
        StPending: begin
          if (frame_start) begin
            disp_q   <= scratch_q;
            overflow <= sat_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel pipeline, stage 1: zone test and digit/row/column lookup.
  logic [10:0] dx, dy, cell_x;
  logic        zone;
  logic [3:0]  digit;
  logic        lit_ok;
  logic        zone_q;
  logic [3:0]  digit_q;
  logic [2:0]  row_q, col_q;
  logic [63:0] g;
`ifdef CASH_LZB_EN
  logic        lead;
`endif

  always_comb begin
    dx     = {1'b0, Q_X} - {1'b0, pos_x};
    dy     = {1'b0, Q_Y} - {1'b0, pos_y};
    zone   = (Q_X >= pos_x) && (16'(Q_X) < 16'(pos_x) + 16'(FieldW)) &&
             (Q_Y >= pos_y) && (16'(Q_Y) < 16'(pos_y) + 16'(CellH));
    cell_x = dx / 11'(SCALE);
    digit  = 4'd0;
    lit_ok = 1'b1;
`ifdef CASH_LZB_EN
    lead   = 1'b1;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (cell_x[10:3] == 8'(i)) begin
        digit = disp_q[(DIGITS-1-i)*4 +: 4];
`ifdef CASH_LZB_EN
        lit_ok = !(lead && (disp_q[(DIGITS-1-i)*4 +: 4] == 4'd0) && (i != DIGITS - 1));
`endif
      end
`ifdef CASH_LZB_EN
      lead = lead && (disp_q[(DIGITS-1-i)*4 +: 4] == 4'd0);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zone_q  <= 1'b0;
      digit_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      zone_q  <= zone && lit_ok;
      digit_q <= digit;
      row_q   <= 3'(dy / 11'(SCALE));
      col_q   <= cell_x[2:0];
    end
  end

  // Stage 2: font row fetch and pixel select.
  assign g = glyph(digit_q);

  always_ff @(posedge clk) begin
    if (rst) visible <= 1'b0;
    else     visible <= zone_q && g[{~row_q, 3'b000} + {3'b000, ~col_q}];
  end

endmodule
